// File: rtl/vadd_seq_ctrl_pkg.sv
// Shared definitions for the vector add/min/max/compare sequencer.
//   - FSM state encoding
//   - element-width (SEW) codes
//   - op-select compare bit index
//   - beat geometry and ALU latency constants
package vadd_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2,
    SEW_64 = 2'd3
  } sew_e;

  localparam int OPSEL_CMP_BIT  = 8;
  localparam int BEAT_BYTES     = 8;
  localparam int ALU_LATENCY    = 6;
  // The ALU latency plus the issue register gives at most 7 beats in
  // flight, so 4 bits leave headroom.
  localparam int INFLIGHT_WIDTH = 4;

endpackage

// File: rtl/vadd_seq_ctrl_beat_calc.sv
// vadd_beat_calc: combinational geometry of one vector instruction.
//   vl      : element count
//   sew     : element width code (0=8b .. 3=64b)
//   opsel   : ALU op-select; only the compare bit matters here
//   beats   : number of 64-bit beats, ceil(vl * bytes_per_elem / 8)
//   tail_be : byte-enable for the final beat
//   is_cmp  : compare op, every write carries only the mask byte
module vadd_beat_calc
  import vadd_seq_ctrl_pkg::*;
#(
  parameter int VL_WIDTH    = 16,
  parameter int SEW_WIDTH   = 2,
  parameter int OPSEL_WIDTH = 9
) (
  input  logic [VL_WIDTH-1:0]    vl,
  input  logic [SEW_WIDTH-1:0]   sew,
  input  logic [OPSEL_WIDTH-1:0] opsel,
  output logic [VL_WIDTH-1:0]    beats,
  output logic [7:0]             tail_be,
  output logic                   is_cmp
);

  // vl << 3 is the widest byte count, so three extra bits hold it and the
  // +7 rounding term without overflow.
  localparam int BYTES_W = VL_WIDTH + 3;

  logic [BYTES_W-1:0] bytes;
  logic [BYTES_W-1:0] rounded;
  logic               unused_opsel;

  always_comb begin
    bytes = '0;
    case (sew)
      SEW_8:   bytes = {3'b000, vl};
      SEW_16:  bytes = {2'b00, vl, 1'b0};
      SEW_32:  bytes = {1'b0, vl, 2'b00};
      default: bytes = {vl, 3'b000};
    endcase
  end

  assign rounded = bytes + BYTES_W'(BEAT_BYTES - 1);
  assign beats   = rounded[BYTES_W-1:3];

  // A byte count that is a multiple of 8 fills the last beat completely.
  assign tail_be = (bytes[2:0] == 3'd0) ? 8'hFF : ((8'h01 << bytes[2:0]) - 8'h01);
  assign is_cmp  = opsel[OPSEL_CMP_BIT];

  assign unused_opsel = ^opsel;

endmodule

// File: rtl/vadd_seq_ctrl.sv
// vadd_seq_ctrl: sequencer in front of the vector ALU pipeline.
//   cmd_*      : one vector instruction (vl, sew, opSel, destination base)
//   opnd_*     : operand-pair stream, one 64-bit beat pair per transfer
//   alu_*      : beats issued to the ALU (registered, one cycle after accept)
//   alu_res_*  : ALU results returning ALU_LATENCY cycles after issue
//   wr_*       : register-file write, registered one cycle after a result
//   done       : one-cycle pulse once the last result has been written
//   err        : sticky, a result arrived while no instruction was active
//   dbg_*      : FSM state and in-flight count for observation
//
// Handshakes: a transfer happens on a cycle where valid && ready are both
// high at the rising clock edge. The producer holds its payload stable while
// valid is high and not accepted. cmd_ready and opnd_ready depend only on
// registered state, never combinationally on the matching valid. The ALU
// result port has no ready: a result is consumed on the cycle it is valid.
module vadd_seq_ctrl
  import vadd_seq_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int SEW_WIDTH   = 2,
  parameter int OPSEL_WIDTH = 9,
  parameter int VL_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [VL_WIDTH-1:0]       cmd_vl,
  input  logic [SEW_WIDTH-1:0]      cmd_sew,
  input  logic [OPSEL_WIDTH-1:0]    cmd_opSel,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic                      opnd_valid,
  output logic                      opnd_ready,
  input  logic [DATA_WIDTH-1:0]     opnd_vec0,
  input  logic [DATA_WIDTH-1:0]     opnd_vec1,
  output logic                      alu_valid,
  output logic [DATA_WIDTH-1:0]     alu_vec0,
  output logic [DATA_WIDTH-1:0]     alu_vec1,
  output logic [SEW_WIDTH-1:0]      alu_sew,
  output logic [OPSEL_WIDTH-1:0]    alu_opSel,
  output logic [ADDR_WIDTH-1:0]     alu_addr,
  input  logic                      alu_res_valid,
  input  logic [DATA_WIDTH-1:0]     alu_res_vec,
  input  logic [ADDR_WIDTH-1:0]     alu_res_addr,
  output logic                      wr_en,
  output logic [ADDR_WIDTH-1:0]     wr_addr,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic [7:0]                wr_be,
  output logic                      done,
  output logic                      err,
  output state_e                    dbg_state,
  output logic [INFLIGHT_WIDTH-1:0] dbg_inflight
);

  state_e state_q, state_d;

  logic [SEW_WIDTH-1:0]      sew_q, sew_d;
  logic [OPSEL_WIDTH-1:0]    opsel_q, opsel_d;
  logic [ADDR_WIDTH-1:0]     cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0]     last_addr_q, last_addr_d;
  logic [VL_WIDTH-1:0]       beats_left_q, beats_left_d;
  logic [7:0]                tail_be_q, tail_be_d;
  logic                      cmp_q, cmp_d;
  logic [INFLIGHT_WIDTH-1:0] inflight_q, inflight_d;

  logic                      alu_valid_q, alu_valid_d;
  logic [DATA_WIDTH-1:0]     alu_vec0_q, alu_vec0_d;
  logic [DATA_WIDTH-1:0]     alu_vec1_q, alu_vec1_d;
  logic [ADDR_WIDTH-1:0]     alu_addr_q, alu_addr_d;

  logic                      wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]     wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic [7:0]                wr_be_q, wr_be_d;
  logic                      err_q, err_d;

  logic [VL_WIDTH-1:0]       calc_beats;
  logic [7:0]                calc_tail_be;
  logic                      calc_is_cmp;

  logic cmd_fire;
  logic opnd_fire;
  logic res_take;
  logic res_stray;

  vadd_beat_calc #(
    .VL_WIDTH    (VL_WIDTH),
    .SEW_WIDTH   (SEW_WIDTH),
    .OPSEL_WIDTH (OPSEL_WIDTH)
  ) u_beat_calc (
    .vl      (cmd_vl),
    .sew     (cmd_sew),
    .opsel   (cmd_opSel),
    .beats   (calc_beats),
    .tail_be (calc_tail_be),
    .is_cmp  (calc_is_cmp)
  );

  assign cmd_fire  = (state_q == ST_IDLE) && cmd_valid;
  assign opnd_fire = (state_q == ST_ISSUE) && (beats_left_q != '0) && opnd_valid;
  assign res_take  = alu_res_valid && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
  assign res_stray = alu_res_valid && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // State register and all datapath flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      sew_q        <= '0;
      opsel_q      <= '0;
      cur_addr_q   <= '0;
      last_addr_q  <= '0;
      beats_left_q <= '0;
      tail_be_q    <= '0;
      cmp_q        <= 1'b0;
      inflight_q   <= '0;
      alu_valid_q  <= 1'b0;
      alu_vec0_q   <= '0;
      alu_vec1_q   <= '0;
      alu_addr_q   <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_be_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sew_q        <= sew_d;
      opsel_q      <= opsel_d;
      cur_addr_q   <= cur_addr_d;
      last_addr_q  <= last_addr_d;
      beats_left_q <= beats_left_d;
      tail_be_q    <= tail_be_d;
      cmp_q        <= cmp_d;
      inflight_q   <= inflight_d;
      alu_valid_q  <= alu_valid_d;
      alu_vec0_q   <= alu_vec0_d;
      alu_vec1_q   <= alu_vec1_d;
      alu_addr_q   <= alu_addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_be_q      <= wr_be_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cmd_valid) state_d = (cmd_vl == '0) ? ST_DONE : ST_ISSUE;
      // beats_left is at least 1 on ISSUE entry, so the last accept is the
      // one that sees exactly one beat remaining.
      ST_ISSUE: if (opnd_fire && (beats_left_q == VL_WIDTH'(1))) state_d = ST_DRAIN;
      // A result arriving this cycle still has to be written, so wait for it.
      ST_DRAIN: if ((inflight_q == '0) && !alu_res_valid) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    sew_d        = sew_q;
    opsel_d      = opsel_q;
    cur_addr_d   = cur_addr_q;
    last_addr_d  = last_addr_q;
    beats_left_d = beats_left_q;
    tail_be_d    = tail_be_q;
    cmp_d        = cmp_q;
    inflight_d   = inflight_q;
    alu_valid_d  = 1'b0;
    alu_vec0_d   = alu_vec0_q;
    alu_vec1_d   = alu_vec1_q;
    alu_addr_d   = alu_addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_be_d      = wr_be_q;
    err_d        = err_q | res_stray;

    if (cmd_fire) begin
      sew_d        = cmd_sew;
      opsel_d      = cmd_opSel;
      cur_addr_d   = cmd_addr;
      last_addr_d  = cmd_addr + ADDR_WIDTH'(calc_beats) - ADDR_WIDTH'(1);
      beats_left_d = calc_beats;
      tail_be_d    = calc_tail_be;
      cmp_d        = calc_is_cmp;
      inflight_d   = '0;
    end

    if (opnd_fire) begin
      alu_valid_d  = 1'b1;
      alu_vec0_d   = opnd_vec0;
      alu_vec1_d   = opnd_vec1;
      alu_addr_d   = cur_addr_q;
      cur_addr_d   = cur_addr_q + ADDR_WIDTH'(1);
      beats_left_d = beats_left_q - VL_WIDTH'(1);
    end

    if (res_take) begin
      wr_en_d   = 1'b1;
      wr_addr_d = alu_res_addr;
      wr_data_d = alu_res_vec;
      if (cmp_q)                             wr_be_d = 8'h01;
      else if (alu_res_addr == last_addr_q)  wr_be_d = tail_be_q;
      else                                   wr_be_d = 8'hFF;
    end

    // An issue and a return in the same cycle cancel out.
    case ({opnd_fire, res_take})
      2'b10:   inflight_d = inflight_q + INFLIGHT_WIDTH'(1);
      2'b01:   inflight_d = inflight_q - INFLIGHT_WIDTH'(1);
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    cmd_ready    = (state_q == ST_IDLE);
    opnd_ready   = (state_q == ST_ISSUE) && (beats_left_q != '0);
    done         = (state_q == ST_DONE);
    dbg_state    = state_q;
    dbg_inflight = inflight_q;
  end

  assign alu_valid = alu_valid_q;
  assign alu_vec0  = alu_vec0_q;
  assign alu_vec1  = alu_vec1_q;
  assign alu_sew   = sew_q;
  assign alu_opSel = opsel_q;
  assign alu_addr  = alu_addr_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_be     = wr_be_q;
  assign err       = err_q;

endmodule

// File: tb/tb_vadd_seq_ctrl.sv
// Directed bench for vadd_seq_ctrl with a 6-cycle ALU model behind it.
module tb_vadd_seq_ctrl;
  import vadd_seq_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_vl = '0;
  logic [1:0]  cmd_sew = '0;
  logic [8:0]  cmd_opSel = '0;
  logic [31:0] cmd_addr = '0;
  logic        opnd_valid = 1'b0;
  logic        opnd_ready;
  logic [63:0] opnd_vec0 = 64'h0102_0304_0506_0708;
  logic [63:0] opnd_vec1 = 64'h1000_0000_0000_0001;
  logic        alu_valid;
  logic [63:0] alu_vec0, alu_vec1;
  logic [1:0]  alu_sew;
  logic [8:0]  alu_opSel;
  logic [31:0] alu_addr;
  logic        alu_res_valid;
  logic [63:0] alu_res_vec;
  logic [31:0] alu_res_addr;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_be;
  logic        done, err;
  state_e      dbg_state;
  logic [3:0]  dbg_inflight;

  vadd_seq_ctrl dut (
    .clk(clk), .rst(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_vl(cmd_vl),
    .cmd_sew(cmd_sew), .cmd_opSel(cmd_opSel), .cmd_addr(cmd_addr),
    .opnd_valid(opnd_valid), .opnd_ready(opnd_ready),
    .opnd_vec0(opnd_vec0), .opnd_vec1(opnd_vec1),
    .alu_valid(alu_valid), .alu_vec0(alu_vec0), .alu_vec1(alu_vec1),
    .alu_sew(alu_sew), .alu_opSel(alu_opSel), .alu_addr(alu_addr),
    .alu_res_valid(alu_res_valid), .alu_res_vec(alu_res_vec),
    .alu_res_addr(alu_res_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .done(done), .err(err), .dbg_state(dbg_state), .dbg_inflight(dbg_inflight)
  );

  // ---------------- ALU model: add, 6 cycles issue-to-result ----------------
  logic [5:0]  p_v;
  logic [63:0] p_d [6];
  logic [31:0] p_a [6];
  logic        spur_valid = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_v <= '0;
    end else begin
      p_v    <= {p_v[4:0], alu_valid};
      p_d[0] <= alu_vec0 + alu_vec1;
      p_a[0] <= alu_addr;
      for (int i = 1; i < 6; i++) begin
        p_d[i] <= p_d[i-1];
        p_a[i] <= p_a[i-1];
      end
    end
  end

  assign alu_res_valid = p_v[5] | spur_valid;
  assign alu_res_vec   = p_d[5];
  assign alu_res_addr  = spur_valid ? 32'h0 : p_a[5];

  // ---------------- monitor ----------------
  logic [31:0] alu_addr_log [$];
  int          alu_cyc_log  [$];
  logic [39:0] wr_log       [$];
  logic [63:0] wr_data_log  [$];
  int          done_log     [$];
  int          max_inflight = 0;

  always @(negedge clk) begin
    if (alu_valid) begin
      alu_addr_log.push_back(alu_addr);
      alu_cyc_log.push_back(cyc);
    end
    if (wr_en) begin
      wr_log.push_back({wr_addr, wr_be});
      wr_data_log.push_back(wr_data);
    end
    if (done) done_log.push_back(cyc);
    if (int'(dbg_inflight) > max_inflight) max_inflight = int'(dbg_inflight);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [39:0] exp_wr_q  [$];
  logic [31:0] exp_alu_q [$];
  int          exp_cyc_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_logs(input string tag);
    check({tag, "_wr_count"}, 64'(wr_log.size()), 64'(exp_wr_q.size()));
    for (int i = 0; i < exp_wr_q.size() && i < wr_log.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), 64'(wr_log[i]), 64'(exp_wr_q[i]));
    check({tag, "_alu_count"}, 64'(alu_addr_log.size()), 64'(exp_alu_q.size()));
    for (int i = 0; i < exp_alu_q.size() && i < alu_addr_log.size(); i++)
      check($sformatf("%s_alu_addr%0d", tag, i), 64'(alu_addr_log[i]), 64'(exp_alu_q[i]));
    for (int i = 0; i < exp_cyc_q.size() && i < alu_cyc_log.size(); i++)
      check($sformatf("%s_alu_cyc%0d", tag, i), 64'(alu_cyc_log[i]), 64'(exp_cyc_q[i]));
    check({tag, "_done_count"}, 64'(done_log.size()), 64'd1);
  endtask

  task automatic clear_logs();
    alu_addr_log.delete(); alu_cyc_log.delete(); wr_log.delete();
    wr_data_log.delete(); done_log.delete();
    exp_wr_q.delete(); exp_alu_q.delete(); exp_cyc_q.delete();
    max_inflight = 0;
  endtask

  // ---------------- driver tasks ----------------
  // Presents an instruction for one cycle; c is the cycle it is accepted in.
  task automatic run_cmd(input logic [15:0] vl, input logic [1:0] sew,
                         input logic [8:0] op, input logic [31:0] addr, output int c);
    @(negedge clk);
    cmd_vl = vl; cmd_sew = sew; cmd_opSel = op; cmd_addr = addr;
    cmd_valid = 1'b1;
    c = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Waits (bounded) for done; optionally toggles opnd_valid every cycle.
  task automatic wait_done(input bit toggle, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < 60 && dcyc < 0; i++) begin
      @(negedge clk);
      if (toggle) opnd_valid = ~opnd_valid;
      if (done) dcyc = cyc;
    end
    opnd_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  int c, dc;

  initial begin
    // Reset state
    #2;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_alu_valid", alu_valid, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_opnd_ready", opnd_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: vl=16 sew=0 -> 2 full beats at 0x100/0x101
    clear_logs();
    opnd_valid = 1'b1;
    run_cmd(16'd16, 2'd0, 9'h000, 32'h100, c);
    check("t1_cmd_ready_busy", cmd_ready, 0);
    wait_done(1'b0, dc);
    exp_wr_q  = '{{32'h100, 8'hFF}, {32'h101, 8'hFF}};
    exp_alu_q = '{32'h100, 32'h101};
    exp_cyc_q = '{c + 2, c + 3};
    check_logs("t1");
    check("t1_done_cyc", 64'(dc), 64'(c + 11));
    check("t1_wr_data", (wr_data_log.size() > 0) ? wr_data_log[0] : 64'hx,
          64'h1102_0304_0506_0709);
    check("t1_max_inflight", 64'(max_inflight), 64'd2);
    check("t1_cmd_ready_back", cmd_ready, 1);

    // 2: vl=5 sew=1 -> 10 bytes, tail be 03
    clear_logs();
    opnd_valid = 1'b1;
    run_cmd(16'd5, 2'd1, 9'h003, 32'h100, c);
    wait_done(1'b0, dc);
    exp_wr_q  = '{{32'h100, 8'hFF}, {32'h101, 8'h03}};
    exp_alu_q = '{32'h100, 32'h101};
    check_logs("t2");
    check("t2_done_cyc", 64'(dc), 64'(c + 11));

    // 3: vl=0 -> done next cycle, nothing issued
    clear_logs();
    opnd_valid = 1'b1;
    run_cmd(16'd0, 2'd2, 9'h000, 32'h500, c);
    check("t3_done_pulse", done, 1);
    check("t3_cmd_ready_low", cmd_ready, 0);
    @(negedge clk);
    check("t3_done_once", done, 0);
    check("t3_cmd_ready_back", cmd_ready, 1);
    opnd_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("t3_no_alu", 64'(alu_addr_log.size()), 0);
    check("t3_no_wr", 64'(wr_log.size()), 0);

    // 4: compare op, vl=3 sew=3 -> 3 beats, mask byte only
    clear_logs();
    opnd_valid = 1'b1;
    run_cmd(16'd3, 2'd3, 9'h100, 32'h300, c);
    wait_done(1'b0, dc);
    exp_wr_q  = '{{32'h300, 8'h01}, {32'h301, 8'h01}, {32'h302, 8'h01}};
    exp_alu_q = '{32'h300, 32'h301, 32'h302};
    check_logs("t4");
    check("t4_done_cyc", 64'(dc), 64'(c + 12));
    check("t4_alu_sew", alu_sew, 2'd3);
    check("t4_alu_opsel", alu_opSel, 9'h100);

    // 4b: compare op with a partial tail (6 bytes) still writes be 01
    clear_logs();
    opnd_valid = 1'b1;
    run_cmd(16'd3, 2'd1, 9'h1FF, 32'h310, c);
    wait_done(1'b0, dc);
    exp_wr_q  = '{{32'h310, 8'h01}};
    exp_alu_q = '{32'h310};
    check_logs("t4b");
    check("t4b_done_cyc", 64'(dc), 64'(c + 10));

    // 5: opnd_valid toggling, vl=32 sew=0 -> 4 beats on alternate cycles
    clear_logs();
    opnd_valid = 1'b1;
    run_cmd(16'd32, 2'd0, 9'h000, 32'h200, c);
    wait_done(1'b1, dc);
    exp_wr_q  = '{{32'h200, 8'hFF}, {32'h201, 8'hFF}, {32'h202, 8'hFF}, {32'h203, 8'hFF}};
    exp_alu_q = '{32'h200, 32'h201, 32'h202, 32'h203};
    exp_cyc_q = '{c + 2, c + 4, c + 6, c + 8};
    check_logs("t5");
    check("t5_done_cyc", 64'(dc), 64'(c + 16));
    check("t5_max_inflight", 64'(max_inflight), 64'd4);

    // 6: 10 back-to-back beats wrapping past 2^32, 76 bytes -> tail 0F at 0x4
    clear_logs();
    opnd_valid = 1'b1;
    run_cmd(16'd76, 2'd0, 9'h000, 32'hFFFF_FFFB, c);
    wait_done(1'b0, dc);
    for (int i = 0; i < 10; i++) begin
      exp_alu_q.push_back(32'hFFFF_FFFB + 32'(i));
      exp_wr_q.push_back({32'hFFFF_FFFB + 32'(i), (i == 9) ? 8'h0F : 8'hFF});
    end
    check_logs("t6");
    check("t6_done_cyc", 64'(dc), 64'(c + 19));
    check("t6_max_inflight", 64'(max_inflight), 64'd7);

    // 7: reset after the first of 4 beats, then a stray ALU result
    clear_logs();
    opnd_valid = 1'b1;
    run_cmd(16'd32, 2'd0, 9'h000, 32'h400, c);
    @(negedge clk);
    opnd_valid = 1'b0;
    check("t7_alu_valid_before_rst", alu_valid, 1);
    @(negedge clk);
    check("t7_state_issue", dbg_state, ST_ISSUE);
    rst_n = 1'b0;
    #1;
    check("t7_rst_cmd_ready", cmd_ready, 1);
    check("t7_rst_opnd_ready", opnd_ready, 0);
    check("t7_rst_alu_addr", alu_addr, 0);
    check("t7_rst_state", dbg_state, ST_IDLE);
    check("t7_rst_inflight", dbg_inflight, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wr_log.delete();
    repeat (10) @(negedge clk);
    check("t7_err_clear", err, 0);
    spur_valid = 1'b1;
    @(negedge clk);
    spur_valid = 1'b0;
    check("t7_err_set", err, 1);
    repeat (3) @(negedge clk);
    check("t7_err_sticky", err, 1);
    check("t7_no_wr", 64'(wr_log.size()), 0);
    check("t7_cmd_ready", cmd_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vadd_seq_ctrl.md
Name: vadd_seq_ctrl

Overview:
- Sequencer in front of the vector add/min/max/compare ALU pipeline.
- Accepts one vector instruction (vl, sew, opSel, destination base address).
- Breaks the instruction into 64-bit beats and streams operand pairs from the operand-fetch stream into the ALU with incrementing addresses.
- Tracks in-flight beats, turns ALU results into register-file writes with tail byte-enables, and pulses done when the final beat has returned.

Parameters:
- DATA_WIDTH, 64, operand/result beat width (fixed 64; 8 bytes per beat)
- ADDR_WIDTH, 32, result address width
- SEW_WIDTH, 2, element width code (0=8b, 1=16b, 2=32b, 3=64b)
- OPSEL_WIDTH, 9, ALU op-select width; bit 8 set means a compare op
- VL_WIDTH, 16, vector length field width, in elements

Ports:
- clk, in, 1: clock
- rst, in, 1: reset, asynchronous, active-low
- cmd_valid, in, 1: instruction valid
- cmd_ready, out, 1: controller idle and able to accept an instruction
- cmd_vl, in, VL_WIDTH: element count
- cmd_sew, in, SEW_WIDTH: element width code
- cmd_opSel, in, OPSEL_WIDTH: ALU operation
- cmd_addr, in, ADDR_WIDTH: destination base address
- opnd_valid, in, 1: operand pair valid
- opnd_ready, out, 1: operand pair accepted this cycle
- opnd_vec0, in, DATA_WIDTH: operand 0 beat
- opnd_vec1, in, DATA_WIDTH: operand 1 beat
- alu_valid, out, 1: beat issued to ALU
- alu_vec0, out, DATA_WIDTH: to ALU
- alu_vec1, out, DATA_WIDTH: to ALU
- alu_sew, out, SEW_WIDTH: to ALU
- alu_opSel, out, OPSEL_WIDTH: to ALU
- alu_addr, out, ADDR_WIDTH: to ALU
- alu_res_valid, in, 1: ALU result valid
- alu_res_vec, in, DATA_WIDTH: ALU result
- alu_res_addr, in, ADDR_WIDTH: ALU result address
- wr_en, out, 1: register-file write strobe
- wr_addr, out, ADDR_WIDTH: write address
- wr_data, out, DATA_WIDTH: write data
- wr_be, out, 8: write byte-enable
- done, out, 1: one-cycle completion pulse
- err, out, 1: sticky flag for an unexpected ALU result

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0, except cmd_ready = 1; all counters and latches cleared. Reset mid-instruction abandons the instruction; the ALU is reset on the same rst.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: cmd_ready = 1. On cmd_valid, latch sew, opSel, addr and compute:
  - bytes = vl << sew
  - beats = (bytes + 7) >> 3
  - tail_be = bytes[2:0] == 0 ? 8'hFF : (8'h01 << bytes[2:0]) - 1
  - if opSel[8] is set, every write uses be = 8'h01 (compare mask byte)
  - last_addr = addr + beats - 1
  - Transition: vl == 0 -> DONE; otherwise -> ISSUE.
- ISSUE:
  - opnd_ready = 1 while beats_left != 0; the ALU has no stall.
  - On opnd_valid && opnd_ready, register the operands; alu_valid = 1 the next cycle with the latched sew/opSel and alu_addr = current address.
  - Then address += 1, beats_left -= 1, inflight += 1.
  - When the final beat is accepted -> DRAIN.
- alu_valid is 0 on every cycle without an accepted beat. alu_vec0/alu_vec1 hold their last values (don't-care).
- Result path, active in ISSUE and DRAIN:
  - alu_res_valid -> next cycle wr_en = 1, wr_addr = alu_res_addr, wr_data = alu_res_vec, inflight -= 1.
  - wr_be = tail_be when alu_res_addr == last_addr (non-compare ops), else 8'hFF.
- Issue and return in the same cycle: inflight is unchanged. inflight is 4 bits; the ALU latency is 6 cycles, so at most 7 beats are in flight.
- DRAIN: when inflight == 0 and no return is pending -> DONE.
- DONE: done = 1 for exactly one cycle -> IDLE. cmd_ready stays 0 from acceptance until IDLE is re-entered.
- alu_res_valid while IDLE or DONE: the result is not written, and err is set (sticky until reset).
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Latency: last operand accepted at cycle t -> alu_valid at t+1 -> ALU result at t+7 -> wr_en at t+8 -> done at t+9.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/ISSUE/DRAIN/DONE)
  - SEW codes
  - OPSEL compare-bit index (8)
  - BEAT_BYTES = 8
  - ALU_LATENCY = 6
- One natural sub-module: vadd_beat_calc, a combinational block taking vl/sew/opSel and producing beats, tail_be and the compare flag.

Test Plan:
- vl=16, sew=0, addr=0x100, operands always valid -> 2 beats at alu_addr 0x100 and 0x101 on consecutive cycles; two writes, both be=FF; done 9 cycles after the 2nd beat is accepted.
- vl=5, sew=1 (10 bytes) -> beats=2; 2nd write at 0x101 with be=8'h03; 1st write be=FF.
- vl=0 -> no alu_valid, no wr_en; done pulses 1 cycle after cmd acceptance; cmd_ready back to 1 the next cycle.
- Compare op opSel=9'h100, vl=3, sew=3 -> 3 beats, every write be=8'h01.
- opnd_valid toggling 1,0,1,0 with vl=32, sew=0 -> alu_valid mirrors accepts delayed 1 cycle; addresses contiguous; inflight never exceeds 7; exactly 4 writes; done once.
- rst asserted mid-ISSUE (after 1 of 4 beats), then a spurious alu_res_valid after release -> all outputs 0, cmd_ready = 1, no wr_en, err = 1.
